// File: rtl/valu_pkg.sv
// Shared types and helpers for the vector ALU sequencer: op codes, SEW constants,
// FSM state encoding and LMUL/SEW decode functions.
package valu_pkg;

    localparam int unsigned SEW_W  = 11;
    localparam int unsigned CTRL_W = 6;
    localparam int unsigned LMUL_W = 2;
    localparam int unsigned BEAT_W = 3;

    typedef enum logic [CTRL_W-1:0] {
        VADD  = 6'd0,
        VSUB  = 6'd1,
        VSLT  = 6'd2,
        VSLTU = 6'd3,
        VAND  = 6'd4,
        VOR   = 6'd5,
        VXOR  = 6'd6,
        VSLL  = 6'd7,
        VSRL  = 6'd8,
        VSRA  = 6'd9
    } alu_op_e;

    localparam logic [SEW_W-1:0] SEW_8   = 11'd8;
    localparam logic [SEW_W-1:0] SEW_16  = 11'd16;
    localparam logic [SEW_W-1:0] SEW_32  = 11'd32;
    localparam logic [SEW_W-1:0] SEW_64  = 11'd64;
    localparam logic [SEW_W-1:0] SEW_128 = 11'd128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } seq_state_e;

    // Number of registers in the group (1, 2, 4 or 8).
    function automatic logic [BEAT_W:0] lmul_beats(input logic [LMUL_W-1:0] lmul);
        return 4'd1 << lmul;
    endfunction

    function automatic logic sew_legal(input logic [SEW_W-1:0] sew);
        case (sew)
            SEW_8, SEW_16, SEW_32, SEW_64, SEW_128: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    // log2 of element size in bytes; only meaningful for legal SEW values.
    function automatic logic [2:0] sew_shift(input logic [SEW_W-1:0] sew);
        case (sew)
            SEW_16:  return 3'd1;
            SEW_32:  return 3'd2;
            SEW_64:  return 3'd3;
            SEW_128: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/valu_tail_merge.sv
// Per-element select between ALU result and old vd: elements at index >= vl keep old vd.
module valu_tail_merge
    import valu_pkg::*;
#(
    parameter int unsigned VLEN = 128,
    parameter int unsigned VL_W = 9
) (
    input  logic [SEW_W-1:0]  sew,
    input  logic [VL_W-1:0]   vl,
    input  logic [BEAT_W-1:0] kw,
    input  logic [VLEN-1:0]   result,
    input  logic [VLEN-1:0]   old,
    output logic [VLEN-1:0]   merged_c
);

    localparam int unsigned NB = VLEN / 8;

    logic [2:0] shift_c;

    assign shift_c = sew_shift(sew);

    // Element index of a byte = its group-wide byte index divided by the element size.
    always_comb begin
        merged_c = old;
        for (int unsigned b = 0; b < NB; b++) begin
            if (((32'(kw) * NB + b) >> shift_c) < 32'(vl)) begin
                merged_c[8*b +: 8] = result[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/valu_seq.sv
// Vector ALU sequencer: walks an LMUL register group one beat per cycle, reads the VRF,
// drives the ALU and writes vd with tail-undisturbed merge. Option: VALU_SEQ_SCALAR_EN.
module valu_seq
    import valu_pkg::*;
#(
    parameter int unsigned VLEN = 128,
    parameter int unsigned VL_W = 9,
    parameter int unsigned RA_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [SEW_W-1:0]    i_sew,
    input  logic [CTRL_W-1:0]   i_ctrl,
    input  logic [LMUL_W-1:0]   i_lmul,
    input  logic [VL_W-1:0]     i_vl,
    input  logic [RA_W-1:0]     i_vs1,
    input  logic [RA_W-1:0]     i_vs2,
    input  logic [RA_W-1:0]     i_vd,
`ifdef VALU_SEQ_SCALAR_EN
    input  logic                i_vx,
    input  logic [63:0]         i_scalar,
`endif
    output logic [RA_W-1:0]     o_rf_raddr_a,
    output logic [RA_W-1:0]     o_rf_raddr_b,
    output logic [RA_W-1:0]     o_rf_raddr_d,
    input  logic [VLEN-1:0]     i_rf_rdata_a,
    input  logic [VLEN-1:0]     i_rf_rdata_b,
    input  logic [VLEN-1:0]     i_rf_rdata_d,
    output logic [SEW_W-1:0]    o_alu_sew,
    output logic [CTRL_W-1:0]   o_alu_ctrl,
    output logic [VLEN-1:0]     o_alu_a,
    output logic [VLEN-1:0]     o_alu_b,
    input  logic [VLEN-1:0]     i_alu_result,
    output logic                o_rf_we,
    output logic [RA_W-1:0]     o_rf_waddr,
    output logic [VLEN-1:0]     o_rf_wdata,
    output logic                o_done,
    output logic                o_err
);

    seq_state_e         state_q, state_d;
    logic [SEW_W-1:0]   sew_q;
    logic [CTRL_W-1:0]  ctrl_q;
    logic [LMUL_W-1:0]  lmul_q;
    logic [VL_W-1:0]    vl_q;
    logic [BEAT_W-1:0]  beat_q, kw_q;
    logic [RA_W-1:0]    raddr_a_q, raddr_b_q, raddr_d_q, waddr_q;
    logic               valid_w_q, ready_q, done_q, err_q;
    logic [VLEN-1:0]    alu_a_hold_q, alu_b_hold_q, operand_b_c;

    logic               accept_c, illegal_c, empty_c;
    logic [RA_W-1:0]    align_mask_c;
    logic [BEAT_W-1:0]  last_beat_c;

    assign accept_c     = i_valid & ready_q;
    assign align_mask_c = RA_W'(lmul_beats(i_lmul) - 4'd1);
    assign illegal_c    = !sew_legal(i_sew) || (32'(i_sew) > VLEN)
                        || ((i_vs1 & align_mask_c) != '0)
                        || ((i_vs2 & align_mask_c) != '0)
                        || ((i_vd  & align_mask_c) != '0);
    assign empty_c      = (i_vl == '0);
    assign last_beat_c  = BEAT_W'(lmul_beats(lmul_q) - 4'd1);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Illegal or empty ops skip straight to FIN so done lands one cycle after acceptance.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, FIN: begin
                state_d = IDLE;
                if (accept_c) state_d = (illegal_c || empty_c) ? FIN : RUN;
            end
            RUN:     if (beat_q == last_beat_c) state_d = DRAIN;
            DRAIN:   state_d = FIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sew_q        <= '0;
            ctrl_q       <= '0;
            lmul_q       <= '0;
            vl_q         <= '0;
            beat_q       <= '0;
            kw_q         <= '0;
            raddr_a_q    <= '0;
            raddr_b_q    <= '0;
            raddr_d_q    <= '0;
            waddr_q      <= '0;
            valid_w_q    <= 1'b0;
            ready_q      <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            alu_a_hold_q <= '0;
            alu_b_hold_q <= '0;
        end else begin
            ready_q   <= (state_d == IDLE) || (state_d == FIN);
            done_q    <= (state_d == FIN);
            err_q     <= accept_c & illegal_c;
            valid_w_q <= (state_q == RUN);
            if (state_q == RUN) begin
                beat_q    <= beat_q + BEAT_W'(1);
                raddr_a_q <= raddr_a_q + RA_W'(1);
                raddr_b_q <= raddr_b_q + RA_W'(1);
                raddr_d_q <= raddr_d_q + RA_W'(1);
                waddr_q   <= raddr_d_q;
                kw_q      <= beat_q;
            end
            if (accept_c) begin
                sew_q     <= i_sew;
                ctrl_q    <= i_ctrl;
                lmul_q    <= i_lmul;
                vl_q      <= i_vl;
                beat_q    <= '0;
                raddr_a_q <= i_vs2;
                raddr_b_q <= i_vs1;
                raddr_d_q <= i_vd;
            end
            if (valid_w_q) begin
                alu_a_hold_q <= i_rf_rdata_a;
                alu_b_hold_q <= operand_b_c;
            end
        end
    end

`ifdef VALU_SEQ_SCALAR_EN
    logic               vx_q;
    logic [63:0]        scalar_q;
    logic [VLEN-1:0]    scalar_rep_c;
    int unsigned        rep_byte_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            vx_q     <= 1'b0;
            scalar_q <= '0;
        end else if (accept_c) begin
            vx_q     <= i_vx;
            scalar_q <= i_scalar;
        end
    end

    // Scalar truncated to SEW (zero-extended beyond 64 bits) and replicated per element.
    always_comb begin
        scalar_rep_c = '0;
        rep_byte_c   = 0;
        for (int unsigned b = 0; b < VLEN / 8; b++) begin
            rep_byte_c = b & ((32'd1 << sew_shift(sew_q)) - 32'd1);
            if (rep_byte_c < 8) scalar_rep_c[8*b +: 8] = scalar_q[8*rep_byte_c +: 8];
        end
    end

    assign operand_b_c = vx_q ? scalar_rep_c : i_rf_rdata_b;
`else
    assign operand_b_c = i_rf_rdata_b;
`endif

    valu_tail_merge #(
        .VLEN (VLEN),
        .VL_W (VL_W)
    ) u_tail_merge (
        .sew      (sew_q),
        .vl       (vl_q),
        .kw       (kw_q),
        .result   (i_alu_result),
        .old      (i_rf_rdata_d),
        .merged_c (o_rf_wdata)
    );

    assign o_ready      = ready_q;
    assign o_rf_raddr_a = raddr_a_q;
    assign o_rf_raddr_b = raddr_b_q;
    assign o_rf_raddr_d = raddr_d_q;
    assign o_alu_sew    = sew_q;
    assign o_alu_ctrl   = ctrl_q;
    assign o_alu_a      = valid_w_q ? i_rf_rdata_a : alu_a_hold_q;
    assign o_alu_b      = valid_w_q ? operand_b_c  : alu_b_hold_q;
    assign o_rf_we      = valid_w_q;
    assign o_rf_waddr   = waddr_q;
    assign o_done       = done_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_valu_seq.sv
// Directed bench for valu_seq with a small VRF and element-wise ALU model.
module tb_valu_seq;
    import valu_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic          o_ready;
    logic [10:0]   i_sew;
    logic [5:0]    i_ctrl;
    logic [1:0]    i_lmul;
    logic [8:0]    i_vl;
    logic [4:0]    i_vs1, i_vs2, i_vd;
`ifdef VALU_SEQ_SCALAR_EN
    logic          i_vx;
    logic [63:0]   i_scalar;
`endif
    logic [4:0]    o_rf_raddr_a, o_rf_raddr_b, o_rf_raddr_d;
    logic [127:0]  i_rf_rdata_a, i_rf_rdata_b, i_rf_rdata_d;
    logic [10:0]   o_alu_sew;
    logic [5:0]    o_alu_ctrl;
    logic [127:0]  o_alu_a, o_alu_b, i_alu_result;
    logic          o_rf_we;
    logic [4:0]    o_rf_waddr;
    logic [127:0]  o_rf_wdata;
    logic          o_done, o_err;

    logic [127:0]  vrf [32];
    int            nwr = 0;
    logic          pl_we = 1'b0;
    logic [4:0]    pl_addr = '0;
    logic [127:0]  pl_data = '0;

    int            n_err = 0;
    int            n_chk = 0;

    always #5 clk = ~clk;

    valu_seq dut (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_sew        (i_sew),
        .i_ctrl       (i_ctrl),
        .i_lmul       (i_lmul),
        .i_vl         (i_vl),
        .i_vs1        (i_vs1),
        .i_vs2        (i_vs2),
        .i_vd         (i_vd),
`ifdef VALU_SEQ_SCALAR_EN
        .i_vx         (i_vx),
        .i_scalar     (i_scalar),
`endif
        .o_rf_raddr_a (o_rf_raddr_a),
        .o_rf_raddr_b (o_rf_raddr_b),
        .o_rf_raddr_d (o_rf_raddr_d),
        .i_rf_rdata_a (i_rf_rdata_a),
        .i_rf_rdata_b (i_rf_rdata_b),
        .i_rf_rdata_d (i_rf_rdata_d),
        .o_alu_sew    (o_alu_sew),
        .o_alu_ctrl   (o_alu_ctrl),
        .o_alu_a      (o_alu_a),
        .o_alu_b      (o_alu_b),
        .i_alu_result (i_alu_result),
        .o_rf_we      (o_rf_we),
        .o_rf_waddr   (o_rf_waddr),
        .o_rf_wdata   (o_rf_wdata),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    // VRF: registered reads, writes from the DUT or from the bench preload port.
    always @(posedge clk) begin
        i_rf_rdata_a <= vrf[o_rf_raddr_a];
        i_rf_rdata_b <= vrf[o_rf_raddr_b];
        i_rf_rdata_d <= vrf[o_rf_raddr_d];
        if (o_rf_we) begin
            vrf[o_rf_waddr] <= o_rf_wdata;
            nwr <= nwr + 1;
        end
        if (pl_we) vrf[pl_addr] <= pl_data;
    end

    function automatic logic [127:0] alu_model(input logic [5:0] c, input logic [10:0] sew,
                                               input logic [127:0] a, input logic [127:0] b);
        logic [127:0] r, m, ae, be, re;
        int w;
        r = '0;
        w = int'(sew);
        if (w == 8 || w == 16 || w == 32 || w == 64 || w == 128) begin
            m = (w == 128) ? '1 : ((128'd1 << w) - 128'd1);
            for (int e = 0; e < 128 / w; e++) begin
                ae = (a >> (e * w)) & m;
                be = (b >> (e * w)) & m;
                case (c)
                    VADD:    re = ae + be;
                    VSUB:    re = ae - be;
                    VAND:    re = ae & be;
                    VOR:     re = ae | be;
                    VXOR:    re = ae ^ be;
                    default: re = ae;
                endcase
                r = r | ((re & m) << (e * w));
            end
        end
        return r;
    endfunction

    always_comb i_alu_result = alu_model(o_alu_ctrl, o_alu_sew, o_alu_a, o_alu_b);

    typedef struct {
        logic [10:0]        sew;
        logic [5:0]         ctrl;
        logic [1:0]         lmul;
        logic [8:0]         vl;
        logic [4:0]         vs1, vs2, vd;
        logic [127:0]       a, b, d;
        int                 lat;
        logic               err;
        int                 nwr;
        int                 nchk;
        logic [3:0][127:0]  exp_d;
    } vec_t;

    localparam int NVEC = 8;
    vec_t tv [NVEC];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [10:0] sew, input logic [5:0] ctrl,
                           input logic [1:0] lmul, input logic [8:0] vl,
                           input logic [4:0] vs1, input logic [4:0] vs2, input logic [4:0] vd,
                           input logic [127:0] a, input logic [127:0] b, input logic [127:0] d,
                           input int lat, input logic err, input int nw, input int nc,
                           input logic [127:0] e0, input logic [127:0] e1,
                           input logic [127:0] e2, input logic [127:0] e3);
        tv[i].sew = sew;   tv[i].ctrl = ctrl; tv[i].lmul = lmul; tv[i].vl = vl;
        tv[i].vs1 = vs1;   tv[i].vs2 = vs2;   tv[i].vd = vd;
        tv[i].a = a;       tv[i].b = b;       tv[i].d = d;
        tv[i].lat = lat;   tv[i].err = err;   tv[i].nwr = nw;   tv[i].nchk = nc;
        tv[i].exp_d[0] = e0; tv[i].exp_d[1] = e1; tv[i].exp_d[2] = e2; tv[i].exp_d[3] = e3;
    endtask

    task automatic preload(input logic [4:0] addr, input logic [127:0] data);
        @(negedge clk);
        pl_we = 1'b1; pl_addr = addr; pl_data = data;
        @(posedge clk);
        #1 pl_we = 1'b0;
    endtask

    task automatic issue(input logic [10:0] sew, input logic [5:0] ctrl, input logic [1:0] lmul,
                         input logic [8:0] vl, input logic [4:0] vs1, input logic [4:0] vs2,
                         input logic [4:0] vd);
        @(negedge clk);
        i_valid = 1'b1; i_sew = sew; i_ctrl = ctrl; i_lmul = lmul; i_vl = vl;
        i_vs1 = vs1; i_vs2 = vs2; i_vd = vd;
        @(posedge clk);
        #1 i_valid = 1'b0;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int   n, lat, wb;
        logic seen, got_err;
        v = tv[i];
        n = 1 << v.lmul;
        for (int k = 0; k < n; k++) begin
            preload(5'(v.vs2 + 5'(k)), v.a);
            preload(5'(v.vs1 + 5'(k)), v.b);
            preload(5'(v.vd + 5'(k)), v.d);
        end
        wb = nwr;
        issue(v.sew, v.ctrl, v.lmul, v.vl, v.vs1, v.vs2, v.vd);
        lat = 0; seen = 1'b0; got_err = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1 && v.lat > 1) chk($sformatf("v%0d_ready_busy", i), 128'(o_ready), 128'(0));
            if (o_done) begin
                seen = 1'b1;
                got_err = o_err;
            end
        end
        chk($sformatf("v%0d_latency", i), 128'(lat), 128'(v.lat));
        chk($sformatf("v%0d_err", i), 128'(got_err), 128'(v.err));
        chk($sformatf("v%0d_writes", i), 128'(nwr - wb), 128'(v.nwr));
        for (int k = 0; k < v.nchk; k++)
            chk($sformatf("v%0d_vd%0d", i, k), vrf[5'(v.vd + 5'(k))], v.exp_d[k]);
        @(negedge clk);
        chk($sformatf("v%0d_done_pulse", i), 128'(o_done), 128'(0));
    endtask

    initial begin
        int wb, bad;
        rst = 1'b1; i_valid = 1'b0; i_sew = '0; i_ctrl = '0; i_lmul = '0; i_vl = '0;
        i_vs1 = '0; i_vs2 = '0; i_vd = '0;
`ifdef VALU_SEQ_SCALAR_EN
        i_vx = 1'b0; i_scalar = '0;
`endif
        set_vec(0, 11'd32, VADD, 2'd0, 9'd4, 5'd1, 5'd2, 5'd3,
                {4{32'h2}}, {4{32'h1}}, '0, 3, 1'b0, 1, 1,
                {4{32'h3}}, '0, '0, '0);
        set_vec(1, 11'd8, VXOR, 2'd1, 9'd20, 5'd10, 5'd8, 5'd4,
                {16{8'h0F}}, {16{8'hF0}}, {16{8'hAA}}, 4, 1'b0, 2, 2,
                {16{8'hFF}}, 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_FFFFFFFF, '0, '0);
        set_vec(2, 11'd32, VADD, 2'd0, 9'd0, 5'd1, 5'd2, 5'd3,
                '0, '0, 128'h77, 1, 1'b0, 0, 1,
                128'h77, '0, '0, '0);
        set_vec(3, 11'd32, VADD, 2'd2, 9'd4, 5'd20, 5'd16, 5'd6,
                '0, '0, 128'h66, 1, 1'b1, 0, 1,
                128'h66, '0, '0, '0);
        set_vec(4, 11'h030, VADD, 2'd0, 9'd4, 5'd1, 5'd2, 5'd3,
                '0, '0, 128'h30, 1, 1'b1, 0, 1,
                128'h30, '0, '0, '0);
        set_vec(5, 11'd128, VSUB, 2'd0, 9'd1, 5'd13, 5'd12, 5'd14,
                128'h5, 128'h3, 128'hDEAD, 3, 1'b0, 1, 1,
                128'h2, '0, '0, '0);
        set_vec(6, 11'd64, VAND, 2'd2, 9'd3, 5'd20, 5'd16, 5'd24,
                '1, {2{64'h1234}}, {2{64'h5555555555555555}}, 6, 1'b0, 4, 4,
                {2{64'h1234}}, {64'h5555555555555555, 64'h1234},
                {2{64'h5555555555555555}}, {2{64'h5555555555555555}});
        set_vec(7, 11'd16, VOR, 2'd0, 9'd5, 5'd2, 5'd1, 5'd7,
                {8{16'h00F0}}, {8{16'h0F00}}, {8{16'hBEEF}}, 3, 1'b0, 1, 1,
                128'hBEEF_BEEF_BEEF_0FF0_0FF0_0FF0_0FF0_0FF0, '0, '0, '0);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", 128'(o_ready), 128'(1));
        chk("reset_we", 128'(o_rf_we), 128'(0));
        chk("reset_done", 128'(o_done), 128'(0));
        chk("reset_err", 128'(o_err), 128'(0));

        for (int i = 0; i < NVEC; i++) run_vec(i);

        // Reset in the middle of an 8-beat op, then a fresh op must complete.
        issue(11'd32, VADD, 2'd3, 9'd32, 5'd16, 5'd8, 5'd24);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_we", 128'(o_rf_we), 128'(0));
        chk("midrst_ready", 128'(o_ready), 128'(1));
        chk("midrst_done", 128'(o_done), 128'(0));
        wb = nwr; bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (o_rf_we || o_done) bad++;
        end
        chk("midrst_quiet", 128'(bad), 128'(0));
        chk("midrst_writes", 128'(nwr - wb), 128'(0));
        run_vec(0);

`ifdef VALU_SEQ_SCALAR_EN
        begin
            int lat;
            preload(5'd2, {8{16'h0001}});
            preload(5'd9, '1);
            preload(5'd10, '0);
            i_vx = 1'b1; i_scalar = 64'h1_0005;
            issue(11'd16, VADD, 2'd0, 9'd8, 5'd9, 5'd2, 5'd10);
            i_vx = 1'b0;
            lat = 0;
            while (!o_done && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            chk("vx_latency", 128'(lat), 128'(3));
            chk("vx_vd", vrf[10], {8{16'h0006}});
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
